// File: rtl/button_pkg.sv
// Shared types and constants for the pushbutton reader: FSM states, counter width
// and default 12 MHz timing constants.
package button_pkg;

  typedef enum logic [1:0] {
    RELEASED,
    CONFIRM_PRESS,
    HELD,
    CONFIRM_RELEASE
  } btn_state_t;

  localparam int PRESS_COUNT_W = 8;

  // 10 ms and 1 s at 12 MHz
  localparam int DEFAULT_DEBOUNCE_CYCLES   = 120000;
  localparam int DEFAULT_LONG_PRESS_CYCLES = 12000000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous board inputs; both stages reset to
// RESET_VALUE so consumers see a known idle level straight out of reset.
module sync_2ff #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             i_clk,
  input  logic             i_srst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_s1 <= RESET_VALUE;
      r_s2 <= RESET_VALUE;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/button_reader.sv
// Debounced pushbutton reader: level, press/release strobes and a wrapping press
// counter. Define BUTTON_READER_LONG_PRESS_EN to enable the long_press strobe.
module button_reader
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
  parameter bit ACTIVE_LOW        = 1'b1,
  parameter int LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES
) (
  input  logic                     clock_12mhz,
  input  logic                     reset,
  input  logic                     button_pin,
  output logic                     pressed,
  output logic                     press_pulse,
  output logic                     release_pulse,
  output logic [PRESS_COUNT_W-1:0] press_count,
  output logic                     long_press
);

  localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic                     w_raw;
  logic                     w_s2;
  btn_state_t               r_state;
  btn_state_t               w_state_next;
  logic [DB_W-1:0]          r_db_cnt;
  logic [DB_W-1:0]          w_db_cnt_next;
  logic                     r_pressed;
  logic                     w_pressed_next;
  logic                     r_press_pulse;
  logic                     w_press_pulse_next;
  logic                     r_release_pulse;
  logic                     w_release_pulse_next;
  logic [PRESS_COUNT_W-1:0] r_press_count;
  logic [PRESS_COUNT_W-1:0] w_press_count_next;

  // raw = 1 always means "button pressed", whatever the board wiring
  assign w_raw = button_pin ^ ACTIVE_LOW;

  sync_2ff #(
    .WIDTH       (1),
    .RESET_VALUE (1'b0)
  ) u_sync (
    .i_clk  (clock_12mhz),
    .i_srst (reset),
    .i_d    (w_raw),
    .o_q    (w_s2)
  );

  always_ff @(posedge clock_12mhz) begin
    if (reset) begin
      r_state         <= RELEASED;
      r_db_cnt        <= '0;
      r_pressed       <= 1'b0;
      r_press_pulse   <= 1'b0;
      r_release_pulse <= 1'b0;
      r_press_count   <= '0;
    end else begin
      r_state         <= w_state_next;
      r_db_cnt        <= w_db_cnt_next;
      r_pressed       <= w_pressed_next;
      r_press_pulse   <= w_press_pulse_next;
      r_release_pulse <= w_release_pulse_next;
      r_press_count   <= w_press_count_next;
    end
  end

  always_comb begin
    w_state_next         = r_state;
    w_db_cnt_next        = r_db_cnt;
    w_pressed_next       = r_pressed;
    w_press_pulse_next   = 1'b0;
    w_release_pulse_next = 1'b0;
    w_press_count_next   = r_press_count;
    case (r_state)
      RELEASED: begin
        if (w_s2) begin
          w_state_next  = CONFIRM_PRESS;
          w_db_cnt_next = DB_W'(1);
        end
      end
      CONFIRM_PRESS: begin
        // Any reversal throws the candidate away and restarts from the stable state
        if (!w_s2) begin
          w_state_next  = RELEASED;
          w_db_cnt_next = '0;
        end else if (r_db_cnt == DB_LAST) begin
          w_state_next       = HELD;
          w_db_cnt_next      = '0;
          w_pressed_next     = 1'b1;
          w_press_pulse_next = 1'b1;
          w_press_count_next = r_press_count + 1'b1;
        end else begin
          w_db_cnt_next = r_db_cnt + 1'b1;
        end
      end
      HELD: begin
        if (!w_s2) begin
          w_state_next  = CONFIRM_RELEASE;
          w_db_cnt_next = DB_W'(1);
        end
      end
      CONFIRM_RELEASE: begin
        if (w_s2) begin
          w_state_next  = HELD;
          w_db_cnt_next = '0;
        end else if (r_db_cnt == DB_LAST) begin
          w_state_next         = RELEASED;
          w_db_cnt_next        = '0;
          w_pressed_next       = 1'b0;
          w_release_pulse_next = 1'b1;
        end else begin
          w_db_cnt_next = r_db_cnt + 1'b1;
        end
      end
      default: begin
        w_state_next  = RELEASED;
        w_db_cnt_next = '0;
      end
    endcase
  end

  assign pressed       = r_pressed;
  assign press_pulse   = r_press_pulse;
  assign release_pulse = r_release_pulse;
  assign press_count   = r_press_count;

`ifdef BUTTON_READER_LONG_PRESS_EN
  localparam int              LP_W    = $clog2(LONG_PRESS_CYCLES) + 1;
  localparam logic [LP_W-1:0] LP_LAST = LP_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [LP_W-1:0] LP_SAT  = LP_W'(LONG_PRESS_CYCLES);

  logic [LP_W-1:0] r_hold_cnt;
  logic            r_long_press;
  logic            w_in_hold;

  assign w_in_hold = (r_state == HELD) || (r_state == CONFIRM_RELEASE);

  // Cleared only on an accepted press, so a release bounce cannot re-arm the strobe
  always_ff @(posedge clock_12mhz) begin
    if (reset) begin
      r_hold_cnt   <= '0;
      r_long_press <= 1'b0;
    end else begin
      r_long_press <= w_in_hold && (r_hold_cnt == LP_LAST);
      if (w_press_pulse_next) begin
        r_hold_cnt <= '0;
      end else if (w_in_hold && (r_hold_cnt != LP_SAT)) begin
        r_hold_cnt <= r_hold_cnt + 1'b1;
      end
    end
  end

  assign long_press = r_long_press;
`else
  // Evaluates to 0 for every legal threshold; the hold counter is compiled out
  assign long_press = (LONG_PRESS_CYCLES < 0);
`endif

endmodule

// File: tb/tb_button_reader.sv
// Randomised + directed bench for button_reader against a run-length debounce model
// (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=10, ACTIVE_LOW=1).
module tb_button_reader;

  localparam int D = 4;
  localparam int L = 10;
`ifdef BUTTON_READER_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       pin;
  logic       pressed;
  logic       press_pulse;
  logic       release_pulse;
  logic [7:0] press_count;
  logic       long_press;

  int checks = 0;
  int errors = 0;

  button_reader #(
    .DEBOUNCE_CYCLES   (D),
    .ACTIVE_LOW        (1'b1),
    .LONG_PRESS_CYCLES (L)
  ) dut (
    .clock_12mhz   (clk),
    .reset         (reset),
    .button_pin    (pin),
    .pressed       (pressed),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .press_count   (press_count),
    .long_press    (long_press)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: the level flips once the 2-cycle-delayed raw input has disagreed
  // with it on D consecutive clock edges.
  bit m_valid = 1'b0;
  bit m_s1, m_s2, m_sample, m_level;
  bit m_pp, m_rp, m_long;
  int m_run, m_held, m_cnt;

  always @(posedge clk) begin
    if (reset) begin
      m_s1 = 0; m_s2 = 0; m_level = 0; m_run = 0; m_held = 0; m_cnt = 0;
      m_pp = 0; m_rp = 0; m_long = 0; m_valid = 1;
    end else begin
      m_sample = m_s2;
      m_s2 = m_s1;
      m_s1 = ~pin;
      m_pp = 0; m_rp = 0; m_long = 0;
      if (m_level && m_held < L) begin
        m_held++;
        if (m_held == L) m_long = LONG_EN;
      end
      if (m_sample != m_level) begin
        m_run++;
        if (m_run == D) begin
          m_run = 0;
          m_level = !m_level;
          if (m_level) begin
            m_pp = 1;
            m_cnt = (m_cnt + 1) % 256;
            m_held = 0;
          end else begin
            m_rp = 1;
          end
        end
      end else begin
        m_run = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("pressed", pressed, m_level);
      chk("press_pulse", press_pulse, m_pp);
      chk("release_pulse", release_pulse, m_rp);
      chk("press_count", press_count, m_cnt);
      chk("long_press", long_press, m_long);
      chk("strobe_exclusive", press_pulse & release_pulse, 0);
      if (press_pulse)   $display("press   accepted t=%0t count=%0d", $time, press_count);
      if (release_pulse) $display("release accepted t=%0t", $time);
      if (long_press)    $display("long    press    t=%0t", $time);
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  // Cycles until pressed == want (0 if it never happens within the budget)
  task automatic wait_level(input logic want, output int n);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (pressed == want) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, lp, pp_n, rp_n, len;
    pin = 1'b1;
    reset = 1'b1;
    repeat (3) step();
    chk("reset_pressed", pressed, 0);
    chk("reset_count", press_count, 0);
    chk("reset_strobes", press_pulse | release_pulse | long_press, 0);
    reset = 1'b0;
    repeat (3) step();

    // Clean press with a long hold
    pin = 1'b0;
    wait_level(1'b1, n);
    chk("press_latency", n, 6);
    chk("press_pulse_at_accept", press_pulse, 1);
    chk("count_after_first", press_count, 1);
    lp = 0;
    for (int k = 1; k <= 25; k++) begin
      step();
      if (long_press && lp == 0) lp = k;
    end
    chk("long_press_delay", lp, LONG_EN ? 10 : 0);
    pin = 1'b1;
    wait_level(1'b0, n);
    chk("release_latency", n, 6);
    $display("scenario clean_press done");

    // Glitch shorter than the window
    repeat (4) step();
    pin = 1'b0;
    repeat (3) step();
    pin = 1'b1;
    repeat (10) step();
    chk("glitch_count", press_count, 1);
    chk("glitch_pressed", pressed, 0);
    $display("scenario glitch done");

    // Short hold: never reaches the long-press threshold
    pin = 1'b0;
    wait_level(1'b1, n);
    pin = 1'b1;
    lp = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (long_press) lp++;
    end
    chk("short_hold_long", lp, 0);
    chk("short_hold_count", press_count, 2);
    $display("scenario short_hold done");

    // Bounce then stable low
    pin = 1'b0; step();
    pin = 1'b1; step();
    pin = 1'b0; step();
    pin = 1'b1; step();
    pin = 1'b0;
    wait_level(1'b1, n);
    chk("bounce_latency", n, 6);
    chk("bounce_count", press_count, 3);
    pin = 1'b1;
    wait_level(1'b0, n);
    $display("scenario bounce done");

    // Reset mid-confirm (counter = 2), pin held low through reset
    repeat (3) step();
    pin = 1'b0;
    repeat (4) step();
    reset = 1'b1;
    step();
    chk("midreset_pressed", pressed, 0);
    chk("midreset_strobe", press_pulse, 0);
    chk("midreset_count", press_count, 0);
    reset = 1'b0;
    wait_level(1'b1, n);
    chk("held_through_reset_latency", n, 6);
    chk("held_through_reset_count", press_count, 1);
    pin = 1'b1;
    wait_level(1'b0, n);
    $display("scenario reset done");

    // Wrap: 256 press/release pairs from reset, then one more
    reset = 1'b1;
    step();
    reset = 1'b0;
    pp_n = 0;
    rp_n = 0;
    for (int p = 0; p < 257; p++) begin
      pin = 1'b0;
      for (int k = 0; k < 8; k++) begin
        step();
        pp_n += int'(press_pulse);
        rp_n += int'(release_pulse);
      end
      if (p == 255) chk("wrap_count_256", press_count, 0);
      pin = 1'b1;
      for (int k = 0; k < 8; k++) begin
        step();
        pp_n += int'(press_pulse);
        rp_n += int'(release_pulse);
      end
      if (p == 255) begin
        chk("wrap_press_pulses", pp_n, 256);
        chk("wrap_release_pulses", rp_n, 256);
      end
    end
    chk("wrap_count_257", press_count, 1);
    $display("scenario wrap done");

    // Random segments with occasional resets
    for (int s = 0; s < 300; s++) begin
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
      end
      pin = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 12);
      repeat (len) step();
    end
    $display("scenario random done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
